// File: rtl/spi_adc_responder_pkg.sv
// Shared definitions for the SPI ADC responder: FSM state encoding,
// default geometry of the transmitted frame and the minimum SCLK
// half-period that the oversampling front end can follow.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LEAD_ZEROS = 3;
  localparam int DEF_FRAME_LEN  = 16;

  // Minimum SCLK half-period in clk cycles: 3 cycles of strobe latency
  // plus one cycle of setup ahead of the master's sampling edge.
  localparam int SPI_MIN_HALF = 4;

  // Number of clk edges after reset before the synchronizer outputs
  // reflect the real pins rather than their reset level.
  localparam logic [1:0] SYNC_SETTLE = 2'd3;

endpackage

// File: rtl/spi_adc_responder_sync_edge.sv
// Two-flop synchronizer followed by a one-flop edge detector for an
// asynchronous SPI control pin. Rise/fall strobes are one clk wide and
// appear two edges after the pin changes, so any register updated from
// them changes on the third edge.
module spi_sync_edge
  import spi_adc_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the pin and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real pipeline.
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_lvl  = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI ADC responder: oversamples the master's sclk/cs_n in the clk domain
// and shifts out {leading zeros, held sample MSB-first, trailing zeros}.
// Optional feature macro SPI_ADC_RESPONDER_PARITY_EN: when defined, the
// first trailing bit carries the XOR of the transmitted sample.
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEAD_ZEROS = DEF_LEAD_ZEROS,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              sdata,
  output logic              sdata_oe,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overrun
);

  // Bit position of the sample LSB inside the shift register.
  localparam int TRAIL_W = FRAME_LEN - LEAD_ZEROS - DATA_W;
  localparam int CNT_W   = $clog2(FRAME_LEN + 1);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_unused_sclk;

  logic [DATA_W-1:0]    r_hold;
  logic [FRAME_LEN-1:0] w_frame;
  logic [FRAME_LEN-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt;
  state_t               r_state;
  logic [1:0]           r_settle;
  logic                 r_armed;
  logic                 r_sdata, r_sdata_oe, r_busy;
  logic                 r_frame_done, r_frame_abort, r_overrun;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .i_async(cs_n),
    .o_lvl  (w_cs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .i_async(sclk),
    .o_lvl  (w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // Only the falling strobe of sclk drives the shifter.
  assign w_unused_sclk = w_sclk_lvl ^ w_sclk_rise;

  // Holding register: new samples are always accepted, in any state.
  always_ff @(posedge clk) begin
    if (rst) r_hold <= '0;
    else if (sample_valid) r_hold <= sample;
  end

  // Frame image loaded into the shift register at cs_n fall.
  always_comb begin
    // NOTE: give every combinational output a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_frame = '0;
    w_frame[TRAIL_W +: DATA_W] = r_hold;
`ifdef SPI_ADC_RESPONDER_PARITY_EN
    w_frame[TRAIL_W-1] = ^r_hold;
`endif
  end

  // Arm frame start only once the synchronizers carry real pin values and
  // cs_n has been seen high, so a reset taken mid-frame cannot turn the
  // synchronizer's reset level into a false cs_n fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SYNC_SETTLE) r_settle <= r_settle + 2'd1;
      if (r_settle == SYNC_SETTLE && w_cs_lvl) r_armed <= 1'b1;
    end
  end

  // Frame FSM with registered outputs; cs_n rise has priority over sclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_sdata       <= 1'b0;
      r_sdata_oe    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      if (w_cs_rise) begin
        r_frame_done  <= (r_state == ST_DONE);
        r_frame_abort <= (r_state == ST_SHIFT);
        r_state       <= ST_IDLE;
        r_busy        <= 1'b0;
        r_sdata_oe    <= 1'b0;
        r_sdata       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall && r_armed) begin
              r_shift    <= w_frame;
              r_sdata    <= w_frame[FRAME_LEN-1];
              r_cnt      <= '0;
              r_overrun  <= 1'b0;
              r_sdata_oe <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (w_sclk_fall) begin
              r_shift <= r_shift << 1;
              r_cnt   <= r_cnt + 1'b1;
              if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                r_sdata <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_sdata <= r_shift[FRAME_LEN-2];
              end
            end
          end
          ST_DONE: begin
            if (w_sclk_fall) r_overrun <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sdata       = r_sdata;
  assign sdata_oe    = r_sdata_oe;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a behavioural SPI master (sclk idles low,
// samples MISO on each rising edge) drives directed and random frames; the
// expected word is built arithmetically from the held sample.
module tb_spi_adc_responder;
  import spi_adc_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int LZ = DEF_LEAD_ZEROS;
  localparam int FL = DEF_FRAME_LEN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic [DW-1:0] sample = '0;
  logic          sample_valid = 1'b0;
  logic          sdata, sdata_oe, busy, frame_done, frame_abort, overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cyc = 0;
  int abort_cyc = 0;
  logic [DW-1:0] m_hold = '0;

  always #5 clk = ~clk;

  spi_adc_responder dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .sdata       (sdata),
    .sdata_oe    (sdata_oe),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .overrun     (overrun)
  );

  always @(negedge clk) begin
    if (frame_done)  done_cyc++;
    if (frame_abort) abort_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected 16-bit word as the master sees it, MSB = first bit on the wire.
  function automatic logic [FL-1:0] exp_frame(input logic [DW-1:0] s);
    logic [FL-1:0] f;
    f = FL'(s) << (FL - LZ - DW);
`ifdef SPI_ADC_RESPONDER_PARITY_EN
    f = f | (FL'($countones(s) % 2) << (FL - LZ - DW - 1));
`endif
    return f;
  endfunction

  task automatic load(input logic [DW-1:0] v);
    @(negedge clk);
    sample = v;
    sample_valid = 1'b1;
    m_hold = v;
    @(negedge clk);
    sample_valid = 1'b0;
    sample = $urandom();
  endtask

  // One master transaction with n_falls falling sclk edges; returns the
  // bits sampled on the first FL rising edges.
  task automatic master_frame(input int half, input int n_falls, output logic [FL-1:0] cap);
    cap = '0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int j = 0; j < half; j++) begin
      @(negedge clk);
      if (j == 1) check("oe_before_latency", 32'(sdata_oe), 32'd0);
      if (j == 2) begin
        check("oe_after_latency", 32'(sdata_oe), 32'd1);
        check("busy_start", 32'(busy), 32'd1);
        check("overrun_cleared", 32'(overrun), 32'd0);
      end
    end
    for (int i = 0; i < n_falls; i++) begin
      if (i < FL) cap = {cap[FL-2:0], sdata};
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      for (int j = 0; j < half; j++) begin
        @(negedge clk);
        if (j == 2) check("overrun_level", 32'(overrun), 32'(i >= FL));
      end
    end
    cs_n = 1'b1;
  endtask

  // Checks around the cs_n rise issued at the end of master_frame.
  task automatic end_checks(input bit exp_active, input bit exp_done, input bit exp_abort);
    repeat (2) @(negedge clk);
    check("oe_hold_before_rise", 32'(sdata_oe), 32'(exp_active));
    check("pulse_not_early", 32'({frame_done, frame_abort}), 32'd0);
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'(exp_done));
    check("frame_abort_pulse", 32'(frame_abort), 32'(exp_abort));
    check("oe_drop", 32'(sdata_oe), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("sdata_idle_zero", 32'(sdata), 32'd0);
    @(negedge clk);
    check("pulse_width_one", 32'({frame_done, frame_abort}), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [FL-1:0] cap, exp_w, exp_w2;
    int d0, a0, half;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({sdata, sdata_oe, busy, frame_done, frame_abort, overrun}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset", 32'({sdata_oe, busy}), 32'd0);

    // Basic frame with 8'hC5.
    load(8'hC5);
    d0 = done_cyc; a0 = abort_cyc;
    master_frame(12, FL, cap);
    end_checks(1'b1, 1'b1, 1'b0);
    check("c5_word", 32'(cap), 32'h18A0);
    check("c5_model", 32'(cap), 32'(exp_frame(m_hold)));
    check("c5_done_count", 32'(done_cyc - d0), 32'd1);
    check("c5_abort_count", 32'(abort_cyc - a0), 32'd0);
    check("c5_overrun", 32'(overrun), 32'd0);

    // Parity-sensitive sample.
    load(8'hC7);
    master_frame(12, FL, cap);
    end_checks(1'b1, 1'b1, 1'b0);
`ifdef SPI_ADC_RESPONDER_PARITY_EN
    check("c7_word", 32'(cap), 32'h18F0);
`else
    check("c7_word", 32'(cap), 32'h18E0);
`endif

    // New sample mid-frame only affects the following frame.
    load(8'hC6);
    exp_w  = exp_frame(8'hC6);
    exp_w2 = exp_frame(8'h3C);
    fork
      master_frame(12, FL, cap);
      begin
        repeat (100) @(negedge clk);
        load(8'h3C);
      end
    join
    end_checks(1'b1, 1'b1, 1'b0);
    check("midload_current", 32'(cap), 32'(exp_w));
    master_frame(12, FL, cap);
    end_checks(1'b1, 1'b1, 1'b0);
    check("midload_next", 32'(cap), 32'(exp_w2));

    // Abort after 9 falls, then a clean frame.
    load(8'hA5);
    exp_w = exp_frame(m_hold);
    d0 = done_cyc; a0 = abort_cyc;
    master_frame(12, 9, cap);
    end_checks(1'b1, 1'b0, 1'b1);
    check("abort_partial_bits", 32'(cap), 32'(exp_w >> (FL - 9)));
    check("abort_count", 32'(abort_cyc - a0), 32'd1);
    check("abort_no_done", 32'(done_cyc - d0), 32'd0);
    master_frame(12, FL, cap);
    end_checks(1'b1, 1'b1, 1'b0);
    check("after_abort_word", 32'(cap), 32'(exp_w));

    // Two extra falls: sticky overrun, frame still completes.
    d0 = done_cyc;
    master_frame(12, FL + 2, cap);
    end_checks(1'b1, 1'b1, 1'b0);
    check("overrun_word", 32'(cap), 32'(exp_w));
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("overrun_done_count", 32'(done_cyc - d0), 32'd1);

    // Reset during bit 6; the rest of that frame is ignored.
    load(8'hC5);
    d0 = done_cyc; a0 = abort_cyc;
    fork
      master_frame(12, FL, cap);
      begin
        repeat (155) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs",
              32'({sdata, sdata_oe, busy, frame_done, frame_abort, overrun}), 32'd0);
        m_hold = '0;
      end
    join
    end_checks(1'b0, 1'b0, 1'b0);
    check("rst_no_done", 32'(done_cyc - d0), 32'd0);
    check("rst_no_abort", 32'(abort_cyc - a0), 32'd0);
    load(8'hC5);
    master_frame(12, FL, cap);
    end_checks(1'b1, 1'b1, 1'b0);
    check("after_rst_word", 32'(cap), 32'h18A0);

    // Random samples and SCLK rates.
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) != 0) load(DW'($urandom()));
      half = $urandom_range(SPI_MIN_HALF + 2, 14);
      exp_w = exp_frame(m_hold);
      master_frame(half, FL, cap);
      end_checks(1'b1, 1'b1, 1'b0);
      check("random_word", 32'(cap), 32'(exp_w));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

Synthesizable, system-clock-synchronous SPI responder that emulates the serial ADC at the far end of `spi_master_adc`. It oversamples the master's `sclk`/`cs_n` in the `clk` domain and shifts out a fixed-format frame: leading zeros, then the latched sample MSB-first, then trailing zeros on `sdata`. It replaces the behavioural slave model on-board, allowing the FPGA to loop an internal sample source back through the master-ADC path.

## Interface
- `DATA_W`, 8: sample width in bits.
- `LEAD_ZEROS`, 3: zero bits sent before the sample MSB.
- `FRAME_LEN`, 16: total bits per frame. Requires LEAD_ZEROS + DATA_W + 1 <= FRAME_LEN <= 31.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: SPI clock from the master, asynchronous to `clk`.
- `cs_n` input 1: SPI chip select from the master, active-low, asynchronous to `clk`.
- `sdata` output 1: MISO data. Held at 0 whenever `sdata_oe` = 0.
- `sdata_oe` output 1: MISO output enable. High while the synchronized `cs_n` is low.
- `sample` input DATA_W: parallel sample to be transmitted.
- `sample_valid` input 1: loads `sample` into the holding register. Always accepted.
- `busy` output 1: frame in progress (state ≠ IDLE).
- `frame_done` output 1: one-cycle pulse when `cs_n` rises after a complete frame.
- `frame_abort` output 1: one-cycle pulse when `cs_n` rises before FRAME_LEN falling edges.
- `overrun` output 1: sticky flag for extra `sclk` falling edges after frame completion. Cleared at the next frame start.

## Operation
- `sclk` and `cs_n` each pass through a 2-FF synchronizer and a 1-FF edge detector. This produces `cs_fall`, `cs_rise` and `sclk_fall` strobes, plus a synchronized `cs_lvl`.
- Holding register `hold`: loaded when `sample_valid` = 1, in any state. Reset value is 0.
- IDLE:
  - On `cs_fall`, the shift register is loaded as {LEAD_ZEROS'b0, `hold`, zeros} (FRAME_LEN bits). A `sample_valid` in the same cycle is not seen; the old `hold` is used.
  - Also on `cs_fall`: bit counter set to 0, `overrun` cleared, transition to SHIFT.
- SHIFT:
  - `sdata` = shift-register MSB, i.e. bit k of the frame after k detected `sclk_fall` events.
  - Each `sclk_fall` shifts left by one and increments the counter.
  - When the counter reaches FRAME_LEN, transition to DONE.
- DONE:
  - `sdata` = 0.
  - Any `sclk_fall` sets `overrun`.
- Any state with `cs_rise`:
  - Transition to IDLE and set `sdata_oe` = 0.
  - Pulse `frame_done` if the state was DONE; pulse `frame_abort` if the state was SHIFT.
- Simultaneous `cs_rise` and `sclk_fall`: `cs_rise` wins. No shift occurs and no `overrun` is set.
- `cs_fall` outside IDLE is impossible by construction and is ignored.
- `rst` during a frame: return to IDLE immediately. The master's subsequent edges are ignored until the next `cs_fall`.
- Reset values: `sdata` = 0, `sdata_oe` = 0, `busy` = 0, `frame_done` = 0, `frame_abort` = 0, `overrun` = 0, counter = 0, state = IDLE.

## Timing
- Pin-to-strobe latency is 3 `clk` cycles (2 sync + 1 edge).
- `sdata_oe` and the first bit are valid 3 cycles after `cs_n` falls.
- A new bit is valid 3 cycles after each `sclk` falling edge. The master samples on the rising edge, so the `sclk` half-period must be ≥ 4 `clk` cycles; SCLK_HALF = 12 is compliant.
- `frame_done` / `frame_abort` assert 3 cycles after `cs_n` rises, for exactly 1 cycle.
- `overrun` asserts 3 cycles after the offending `sclk` fall.

## Configuration
- `SPI_ADC_RESPONDER_PARITY_EN` defined: frame bit LEAD_ZEROS + DATA_W carries the even parity (XOR) of the transmitted sample. All other trailing bits stay 0.
- `SPI_ADC_RESPONDER_PARITY_EN` undefined: all trailing bits are 0. No parity logic is synthesized.

## Structure
- Shared package `spi_adc_pkg`:
  - State encoding constants (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2).
  - Default `DATA_W` / `LEAD_ZEROS` / `FRAME_LEN`.
  - Minimum half-period constant `SPI_MIN_HALF` = 4.
- Sub-module `spi_sync_edge` (2-FF sync + rise/fall strobes, reset level 1), instantiated for `sclk` and `cs_n`.

## Test plan
- `sample` = 8'hC5, master SCLK_HALF = 12, one frame -> master captures 16'h18A0; `frame_done` pulses once; `overrun` = 0.
- `sample` = 8'hC7 -> master captures 16'h18E0 without the macro, 16'h18F0 with `SPI_ADC_RESPONDER_PARITY_EN`.
- `sample_valid` with 8'h3C mid-frame while sending 8'hC6 -> current frame carries C6; next frame carries 3C.
- `cs_n` raised after 9 `sclk` falls -> `frame_abort` pulses; `frame_done` = 0; `sdata_oe` drops 3 cycles after the rise; next frame is complete and correct.
- 18 `sclk` falls in one frame -> `overrun` = 1 after the 17th fall and cleared at the next `cs_n` fall; `frame_done` still pulses.
- `rst` asserted for 1 cycle during bit 6 -> all outputs at reset values next cycle; remaining edges ignored; following frame sends 16'h18A0 for 8'hC5.
